serial_word_adder: RTL and testbench
====================================

SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

Interface
REQ-001 The block SHALL have a parameter `bit_width`, default 8, giving the width of each operand and sum word.
REQ-002 The block SHALL have a parameter `max_words`, default 16, giving the maximum number of words in one packet.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port `in_valid`, input, 1 bit: the upstream source presents an operand word.
REQ-006 Port `in_ready`, output, 1 bit: the block accepts the word this cycle.
REQ-007 Port `in_a`, input, `bit_width` bits: operand A word, least-significant word first.
REQ-008 Port `in_b`, input, `bit_width` bits: operand B word, least-significant word first.
REQ-009 Port `in_carry`, input, 1 bit: packet carry-in, sampled only on the first word of a packet.
REQ-010 Port `in_last`, input, 1 bit: marks the final word of a packet.
REQ-011 Port `out_valid`, output, 1 bit: a sum word is presented.
REQ-012 Port `out_ready`, input, 1 bit: the downstream sink accepts the sum word.
REQ-013 Port `out_sum`, output, `bit_width` bits: the sum word.
REQ-014 Port `out_carry`, output, 1 bit: the carry out of this word; it is the packet carry-out when `out_last`=1.
REQ-015 Port `out_last`, output, 1 bit: marks the final sum word of a packet.
REQ-016 Port `out_index`, output, clog2(`max_words`) bits: the 0-based position of the word within its packet.
REQ-017 Port `out_error`, output, 1 bit: the packet was truncated because it reached `max_words` words.

Function
REQ-018 An input transfer SHALL occur on a cycle where `in_valid`=1, `in_ready`=1 and `rst`=0.
REQ-019 `in_ready` SHALL equal (!`out_valid` || `out_ready`) && !`rst`; it is combinational, giving a one-entry output register with no bubble.
REQ-020 The state machine SHALL have two states: IDLE (next word is the first of a packet) and ACTIVE (packet in progress).
REQ-021 The effective carry SHALL be `in_carry` in IDLE and the internal carry register in ACTIVE.
REQ-022 On a transfer, the block SHALL compute a (`bit_width`+1)-bit sum `in_a` + `in_b` + effective carry, with zero-extended operands.
REQ-023 On a transfer, `out_sum` SHALL load the low `bit_width` bits of the sum, and both `out_carry` and the carry register SHALL load bit `bit_width`.
REQ-024 On a transfer, `out_valid` SHALL go to 1 on the next cycle, giving a latency of 1 cycle.
REQ-025 On a transfer, `out_index` SHALL load the word counter and `out_last` SHALL load the effective last flag.
REQ-026 The word counter SHALL be 0 in IDLE and SHALL increment on each transfer in ACTIVE.
REQ-027 The effective last flag SHALL be `in_last` || (counter == `max_words`-1).
REQ-028 `out_error` SHALL load 1 when the counter equals `max_words`-1 and `in_last`=0; otherwise it SHALL load 0.
REQ-029 Transition IDLE->ACTIVE SHALL occur on a transfer whose effective last flag is 0.
REQ-030 Transition ACTIVE->IDLE SHALL occur on a transfer whose effective last flag is 1; the carry register and counter SHALL then clear to 0.
REQ-031 A transfer in IDLE with the effective last flag at 1 SHALL be a single-word packet, and the block SHALL remain in IDLE.
REQ-032 When `out_valid`=1 and `out_ready`=0, every output SHALL hold stable and no transfer SHALL occur.
REQ-033 When `out_valid`=1, `out_ready`=1 and `in_valid`=0, `out_valid` SHALL drop to 0 on the next cycle; state, carry and counter SHALL be unchanged.
REQ-034 If `out_ready`=1 and a transfer occur in the same cycle, the output register SHALL be replaced by the new word, and `out_valid` SHALL remain 1.
REQ-035 With `in_valid`=0, state, carry and counter SHALL never change, so gaps within a packet are legal.
REQ-036 Packets SHALL be contiguous and SHALL NOT interleave.

Reset
REQ-037 While `rst`=1 at a clock edge, the block SHALL set `out_valid`=0, `out_sum`=0, `out_carry`=0, `out_last`=0, `out_index`=0 and `out_error`=0.
REQ-038 While `rst`=1 at a clock edge, the block SHALL set state to IDLE, the carry register to 0 and the counter to 0.
REQ-039 A reset mid-packet SHALL discard the partial packet and any pending output word, and the next transfer SHALL be treated as a first word.
REQ-040 `in_ready` SHALL be 0 during every cycle in which `rst`=1.

Verification (`bit_width`=8, `max_words`=4 unless stated)
REQ-041 The bench SHALL cover a single word: a=0xFF, b=0x01, cin=0, last=1 -> next cycle `out_sum`=0x00, `out_carry`=1, `out_last`=1, `out_index`=0, `out_error`=0.
REQ-042 The bench SHALL cover a three-word packet: (FF,01,cin=0), (FF,00), (00,00,last=1) -> sums 0x00, 0x00, 0x01; `out_index` 0, 1, 2; `out_last` only on the third word, with final `out_carry`=0.
REQ-043 The bench SHALL cover carry isolation: word 1 (00,00,cin=1), then word 2 (00,00,cin=1,last) -> sums 0x01, 0x00; `in_carry` on word 2 is ignored.
REQ-044 The bench SHALL cover backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1 -> `in_ready`=0 and outputs stable; then raise `out_ready` with `in_valid` held -> one transfer per cycle with no bubble.
REQ-045 The bench SHALL cover reset after word 0 of a packet -> all outputs 0; the next word (10,20,cin=1,last) gives `out_sum`=0x31 with `out_index`=0.
REQ-046 The bench SHALL cover overrun: 5 words, none marked last -> word index 3 gives `out_last`=1 and `out_error`=1; word 5 starts a new packet with `out_index`=0 and uses `in_carry`.

Source files
------------

// File: rtl/serial_word_adder.sv
// Adds two multi-word operands least-significant word first, chaining the carry across words; 1-cycle latency.
// The output is a one-entry register: in_ready = (!out_valid || out_ready) && !rst, so a full pipe streams without bubbles.
module serial_word_adder #(
    parameter int bit_width = 8,
    parameter int max_words = 16,
    localparam int IW = (max_words > 1) ? $clog2(max_words) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bit_width-1:0] in_a,
    input  logic [bit_width-1:0] in_b,
    input  logic                 in_carry,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bit_width-1:0] out_sum,
    output logic                 out_carry,
    output logic                 out_last,
    output logic [IW-1:0]        out_index,
    output logic                 out_error
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic                 carry_q, carry_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [bit_width-1:0] out_sum_q, out_sum_d;
    logic                 out_carry_q, out_carry_d;
    logic                 out_last_q, out_last_d;
    logic [IW-1:0]        out_index_q, out_index_d;
    logic                 out_error_q, out_error_d;

    logic                 eff_carry;
    logic                 at_max;
    logic                 eff_last;
    logic                 xfer;
    logic [bit_width:0]   sum;

    assign in_ready  = (!out_valid_q || out_ready) && !rst;
    assign xfer      = in_valid && in_ready;
    assign eff_carry = (state_q == IDLE) ? in_carry : carry_q;
    assign at_max    = (cnt_q == IW'(max_words - 1));
    assign eff_last  = in_last || at_max;
    assign sum       = {1'b0, in_a} + {1'b0, in_b} + {{bit_width{1'b0}}, eff_carry};

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_last_d  = out_last_q;
        out_index_d = out_index_q;
        out_error_d = out_error_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum[bit_width-1:0];
            out_carry_d = sum[bit_width];
            out_last_d  = eff_last;
            out_index_d = cnt_q;
            out_error_d = at_max && !in_last;
            if (eff_last) begin
                // Packet closes (normally or by truncation): next word starts fresh.
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = ACTIVE;
                carry_d = sum[bit_width];
                cnt_d   = cnt_q + IW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            out_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            out_error_q <= out_error_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_last  = out_last_q;
    assign out_index = out_index_q;
    assign out_error = out_error_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Scoreboard bench for serial_word_adder (8-bit words, 4-word packets): packet-level reference model feeds a queue, a monitor pops on every output handshake.
module tb_serial_word_adder;

    localparam int BW = 8;
    localparam int MW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_a, in_b;
    logic          in_carry, in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_sum;
    logic          out_carry, out_last, out_error;
    logic [IW-1:0] out_index;

    serial_word_adder #(.bit_width(BW), .max_words(MW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_carry(in_carry), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_last(out_last),
        .out_index(out_index), .out_error(out_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int carry;
        int last;
        int idx;
        int err;
    } exp_t;

    exp_t   sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    bit     rand_rdy = 1'b0;

    // Reference model: whole packet held as wide integers, each word read out of the running total.
    int     m_pos = 0;
    longint m_acc = 0;
    longint m_cin = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_push(input int a, input int b, input int cin, input int last);
        exp_t   e;
        longint total;
        bit     trunc;
        if (m_pos == 0) begin
            m_acc = 0;
            m_cin = cin;
        end
        m_acc += (longint'(a) + longint'(b)) << (8 * m_pos);
        total  = m_acc + m_cin;
        trunc  = (m_pos == MW - 1);
        e.sum   = int'((total >> (8 * m_pos)) & 64'hFF);
        e.carry = int'((total >> (8 * m_pos + 8)) & 64'h1);
        e.idx   = m_pos;
        e.last  = (last != 0 || trunc) ? 1 : 0;
        e.err   = (trunc && last == 0) ? 1 : 0;
        sb.push_back(e);
        m_pos = (e.last != 0) ? 0 : m_pos + 1;
    endtask

    // Present one word and hold it until accepted; returns the accepting cycle.
    task automatic send(input int a, input int b, input int cin, input int last, output int acc_cyc);
        bit done = 1'b0;
        in_a     = BW'(a);
        in_b     = BW'(b);
        in_carry = cin[0];
        in_last  = last[0];
        in_valid = 1'b1;
        acc_cyc  = -1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                model_push(a, b, cin, last);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose, required acceptance within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain;
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_during_rst", in_ready, 0);
        @(posedge clk);
        #1;
        sb.delete();
        m_pos = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum",   out_sum,   0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_error", out_error, 0);
        rst = 1'b0;
    endtask

    // Monitor: a handshake that will complete on the coming edge is checked here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: sum 0x%0h with empty scoreboard, required no output", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sum",   out_sum,   e.sum);
                chk("out_carry", out_carry, e.carry);
                chk("out_last",  out_last,  e.last);
                chk("out_index", out_index, e.idx);
                chk("out_error", out_error, e.err);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int c0, c1, c2, c3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_carry  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // Single word with carry out
        send(8'hFF, 8'h01, 0, 1, c0);
        drain();

        // Three-word packet rippling a carry
        send(8'hFF, 8'h01, 0, 0, c0);
        send(8'hFF, 8'h00, 0, 0, c0);
        send(8'h00, 8'h00, 0, 1, c0);
        drain();

        // in_carry on a non-first word must be ignored
        send(8'h00, 8'h00, 1, 0, c0);
        send(8'h00, 8'h00, 1, 1, c0);
        drain();

        // Backpressure: output held, input stalled, then streams with no bubble
        out_ready = 1'b0;
        send(8'h12, 8'h34, 0, 0, c0);
        in_a = 8'h01; in_b = 8'h02; in_carry = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_sum_stable", out_sum, sb[0].sum);
            chk("bp_out_index_stable", out_index, sb[0].idx);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h01, 8'h02, 0, 0, c1);
        send(8'h80, 8'h80, 0, 0, c2);
        send(8'h7F, 8'h00, 0, 1, c3);
        chk("no_bubble_1", c2 - c1, 1);
        chk("no_bubble_2", c3 - c2, 1);
        drain();

        // Reset mid-packet discards the pending word and restarts at index 0
        out_ready = 1'b0;
        send(8'hAA, 8'hBB, 1, 0, c0);
        do_reset();
        out_ready = 1'b1;
        send(8'h10, 8'h20, 1, 1, c0);
        drain();

        // Overrun: five unterminated words, truncation at index 3, fifth word uses in_carry
        send(8'hF0, 8'h10, 0, 0, c0);
        send(8'h01, 8'h02, 1, 0, c0);
        send(8'hFF, 8'hFF, 0, 0, c0);
        send(8'h00, 8'h01, 0, 0, c0);
        send(8'h05, 8'h06, 1, 0, c0);
        send(8'h00, 8'h00, 0, 1, c0);
        drain();

        // Randomized traffic with random gaps and random downstream stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap == 3) repeat (int'($urandom_range(1, 3))) @(posedge clk);
            #1;
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 : 0, c0);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
